// File: rtl/lcd_cmd_ctrl.sv
// Buffered HD44780-style LCD writer: a byte FIFO replayed with setup/enable/hold/exec timing.
// Optional power-on init sequence (0x38, 0x0C, 0x01, 0x06) is enabled by defining LCD_INIT_SEQ_EN.
`timescale 1ns/1ps
module lcd_cmd_ctrl #(
    parameter int FIFO_DEPTH     = 8,
    parameter int SETUP_CYC      = 4,
    parameter int EN_HIGH_CYC    = 24,
    parameter int HOLD_CYC       = 2,
    parameter int EXEC_CYC       = 2000,
    parameter int CLEAR_EXEC_CYC = 82000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_wr_en,
    input  logic        i_wr_rs,
    input  logic [7:0]  i_wr_data,
    input  logic        i_ctrl_wr,
    input  logic        i_ctrl_on,
    output logic        o_full,
    output logic [31:0] o_status,
    output logic        o_lcd_on,
    output logic        o_lcd_en,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic [7:0]  o_lcd_data
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int MAX_AB  = (SETUP_CYC > EN_HIGH_CYC) ? SETUP_CYC : EN_HIGH_CYC;
    localparam int MAX_CD  = (HOLD_CYC > EXEC_CYC) ? HOLD_CYC : EXEC_CYC;
    localparam int MAX_AD  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int MAX_CYC = (MAX_AD > CLEAR_EXEC_CYC) ? MAX_AD : CLEAR_EXEC_CYC;
    localparam int TMR_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {IDLE, SETUP, EN_HI, HOLD, EXEC} state_t;

    state_t           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;

    logic [8:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             full, empty, push, pop, busy, is_clear;
    logic             ovf_q, lcd_on_q;
    logic             bus_rs_q, bus_rs_d;
    logic [7:0]       bus_data_q, bus_data_d;
    logic [3:0]       cnt4;
    logic             init_pending;

    assign full     = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign push     = i_wr_en && !full;
    assign is_clear = !bus_rs_q && (bus_data_q >= 8'h01) && (bus_data_q <= 8'h03);

`ifdef LCD_INIT_SEQ_EN
    logic [2:0] init_idx_q;
    logic       init_armed_q;
    logic       init_adv, init_start;
    logic [7:0] init_byte;

    // Armed one cycle after reset release so the reset-time status still reads idle.
    assign init_pending = init_armed_q && (init_idx_q < 3'd4);
    assign init_start   = init_adv && (init_idx_q == 3'd0);

    always_comb begin
        case (init_idx_q[1:0])
            2'd0:    init_byte = 8'h38;
            2'd1:    init_byte = 8'h0C;
            2'd2:    init_byte = 8'h01;
            default: init_byte = 8'h06;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            init_idx_q   <= '0;
            init_armed_q <= 1'b0;
        end else begin
            init_armed_q <= 1'b1;
            if (init_adv)
                init_idx_q <= init_idx_q + 3'd1;
        end
    end
`else
    assign init_pending = 1'b0;
`endif

    assign busy = (state_q != IDLE) || !empty || init_pending;

    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        pop        = 1'b0;
        bus_rs_d   = bus_rs_q;
        bus_data_d = bus_data_q;
`ifdef LCD_INIT_SEQ_EN
        init_adv   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
`ifdef LCD_INIT_SEQ_EN
                if (init_pending) begin
                    init_adv   = 1'b1;
                    bus_rs_d   = 1'b0;
                    bus_data_d = init_byte;
                    state_d    = SETUP;
                    tmr_d      = TMR_W'(SETUP_CYC - 1);
                end else
`endif
                if (!empty) begin
                    pop        = 1'b1;
                    bus_rs_d   = fifo_mem[rd_ptr_q][8];
                    bus_data_d = fifo_mem[rd_ptr_q][7:0];
                    state_d    = SETUP;
                    tmr_d      = TMR_W'(SETUP_CYC - 1);
                end
            end
            SETUP: begin
                if (tmr_q == '0) begin
                    state_d = EN_HI;
                    tmr_d   = TMR_W'(EN_HIGH_CYC - 1);
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            EN_HI: begin
                if (tmr_q == '0) begin
                    state_d = HOLD;
                    tmr_d   = TMR_W'(HOLD_CYC - 1);
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            HOLD: begin
                // Clear-display and return-home need the long panel execution time.
                if (tmr_q == '0) begin
                    state_d = EXEC;
                    tmr_d   = is_clear ? TMR_W'(CLEAR_EXEC_CYC - 1) : TMR_W'(EXEC_CYC - 1);
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            EXEC: begin
                if (tmr_q == '0)
                    state_d = IDLE;
                else
                    tmr_d = tmr_q - TMR_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            tmr_q      <= '0;
            bus_rs_q   <= 1'b0;
            bus_data_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            bus_rs_q   <= bus_rs_d;
            bus_data_q <= bus_data_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push)
            fifo_mem[wr_ptr_q] <= {i_wr_rs, i_wr_data};
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // A dropped write sets overflow even when a control write clears it the same cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ovf_q    <= 1'b0;
            lcd_on_q <= 1'b0;
        end else begin
            if (i_wr_en && full)
                ovf_q <= 1'b1;
            else if (i_ctrl_wr)
                ovf_q <= 1'b0;
            if (i_ctrl_wr)
                lcd_on_q <= i_ctrl_on;
`ifdef LCD_INIT_SEQ_EN
            else if (init_start)
                lcd_on_q <= 1'b1;
`endif
        end
    end

    assign cnt4       = 4'(count_q);
    assign o_full     = full;
    assign o_status   = {24'h0, cnt4, ovf_q, empty, full, busy};
    assign o_lcd_on   = lcd_on_q;
    assign o_lcd_en   = (state_q == EN_HI);
    assign o_lcd_rs   = bus_rs_q;
    assign o_lcd_rw   = 1'b0;
    assign o_lcd_data = bus_data_q;

endmodule

// File: tb/tb_lcd_cmd_ctrl.sv
// Scoreboard bench for lcd_cmd_ctrl: expected panel bytes queued on write, checked on each EN rise.
`timescale 1ns/1ps
module tb_lcd_cmd_ctrl;
    localparam int SETUP_CYC   = 4;
    localparam int EN_HIGH_CYC = 24;
    localparam int HOLD_CYC    = 2;
    localparam int EXEC_CYC    = 2000;
    localparam int CLR_CYC     = 8200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0, wr_rs = 1'b0, ctrl_wr = 1'b0, ctrl_on = 1'b0;
    logic [7:0]  wr_data = 8'h00;
    logic        full, lcd_on, lcd_en, lcd_rs, lcd_rw;
    logic [31:0] status;
    logic [7:0]  lcd_data;

    int          n_total = 0, n_bad = 0;
    int          cyc = 0;
    logic [8:0]  sb[$];
    int          rise_q[$], fall_q[$];
    logic        en_prev = 1'b0;
    logic [8:0]  sb_head;

    lcd_cmd_ctrl #(
        .FIFO_DEPTH(8), .SETUP_CYC(SETUP_CYC), .EN_HIGH_CYC(EN_HIGH_CYC),
        .HOLD_CYC(HOLD_CYC), .EXEC_CYC(EXEC_CYC), .CLEAR_EXEC_CYC(CLR_CYC)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_rs(wr_rs),
        .i_wr_data(wr_data), .i_ctrl_wr(ctrl_wr), .i_ctrl_on(ctrl_on),
        .o_full(full), .o_status(status), .o_lcd_on(lcd_on), .o_lcd_en(lcd_en),
        .o_lcd_rs(lcd_rs), .o_lcd_rw(lcd_rw), .o_lcd_data(lcd_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Panel-side monitor: every EN rise must carry the oldest expected byte.
    always @(negedge clk) begin
        if (lcd_en && !en_prev) begin
            rise_q.push_back(cyc);
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {23'b0, lcd_rs, lcd_data}, 32'hFFFF_FFFF);
            end else begin
                sb_head = sb.pop_front();
                chk("pulse_byte", {23'b0, lcd_rs, lcd_data}, {23'b0, sb_head});
            end
        end
        if (!lcd_en && en_prev) begin
            fall_q.push_back(cyc);
            if (rst_n && rise_q.size() > 0)
                chk("en_width", cyc - rise_q[rise_q.size()-1], EN_HIGH_CYC);
        end
        en_prev = lcd_en;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic rs, input logic [7:0] d);
        wr_en = 1'b1; wr_rs = rs; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output int c);
        c = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (status[0] == 1'b0) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic release_reset();
`ifdef LCD_INIT_SEQ_EN
        int c;
        int n0;
`endif
        rst_n = 1'b1;
`ifdef LCD_INIT_SEQ_EN
        n0 = rise_q.size();
        sb.push_back({1'b0, 8'h38});
        sb.push_back({1'b0, 8'h0C});
        sb.push_back({1'b0, 8'h01});
        sb.push_back({1'b0, 8'h06});
        tick();
        tick();
        wait_idle(3 * EXEC_CYC + CLR_CYC + 1000, c);
        chk("init_pulses", rise_q.size() - n0, 4);
        chk("init_lcd_on", lcd_on, 1);
        chk("init_sb_empty", sb.size(), 0);
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0; wr_en = 1'b0; ctrl_wr = 1'b0; ctrl_on = 1'b0;
        tick();
        tick();
        chk("rst_status", status, 32'h0000_0004);
        chk("rst_en", lcd_en, 0);
        chk("rst_rs", lcd_rs, 0);
        chk("rst_rw", lcd_rw, 0);
        chk("rst_data", lcd_data, 0);
        chk("rst_on", lcd_on, 0);
        chk("rst_full", full, 0);
        sb.delete();
        rise_q.delete();
        fall_q.delete();
        release_reset();
        rise_q.delete();
        fall_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, c, n0;

        // Single data byte: bus timing, EN window, busy fall.
        do_reset();
        t0 = cyc;
        sb.push_back({1'b1, 8'h41});
        write_byte(1'b1, 8'h41);
        tick();
        chk("t1_rs", lcd_rs, 1);
        chk("t1_data", lcd_data, 8'h41);
        chk("t1_en_setup", lcd_en, 0);
        chk("t1_busy", status[0], 1);
        wait_idle(5000, c);
        chk("t1_busy_fall", c - t0, 2032);
        chk("t1_en_rise", (rise_q.size() > 0) ? rise_q[0] - t0 : -1, 6);
        chk("t1_en_fall", (fall_q.size() > 0) ? fall_q[0] - t0 : -1, 30);
        chk("t1_bus_hold", lcd_data, 8'h41);
        chk("t1_sb_empty", sb.size(), 0);

        // Clear command gets the long wait; 0x04 is an ordinary command.
        do_reset();
        sb.push_back({1'b0, 8'h01}); write_byte(1'b0, 8'h01);
        sb.push_back({1'b0, 8'h04}); write_byte(1'b0, 8'h04);
        sb.push_back({1'b1, 8'h42}); write_byte(1'b1, 8'h42);
        wait_idle(CLR_CYC + 3 * EXEC_CYC + 500, c);
        chk("t2_pulses", rise_q.size(), 3);
        if (rise_q.size() == 3 && fall_q.size() >= 2) begin
            chk("t2_clear_gap", rise_q[1] - fall_q[0], CLR_CYC + HOLD_CYC + SETUP_CYC + 1);
            chk("t2_normal_gap", rise_q[2] - fall_q[1], EXEC_CYC + HOLD_CYC + SETUP_CYC + 1);
        end
        chk("t2_sb_empty", sb.size(), 0);

        // Overflow, then control writes.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            sb.push_back({1'b1, 8'(i)});
            write_byte(1'b1, 8'(i));
        end
        chk("t3_count_full", status[7:4], 8);
        chk("t3_full", full, 1);
        chk("t3_status_full", status[1], 1);
        chk("t3_no_ovf_yet", status[3], 0);
        write_byte(1'b1, 8'h09);
        chk("t3_ovf", status[3], 1);
        chk("t3_count_after_drop", status[7:4], 8);
        ctrl_wr = 1'b1; ctrl_on = 1'b1;
        tick();
        ctrl_wr = 1'b0;
        chk("t3_ctrl_on", lcd_on, 1);
        chk("t3_ctrl_ovf_clr", status[3], 0);
        chk("t3_ctrl_count", status[7:4], 8);
        ctrl_wr = 1'b1; ctrl_on = 1'b1;
        write_byte(1'b1, 8'h0A);
        ctrl_wr = 1'b0;
        chk("t3_set_wins", status[3], 1);
        wait_idle(10 * (EXEC_CYC + 40), c);
        chk("t3_pulses", rise_q.size(), 9);
        chk("t3_sb_empty", sb.size(), 0);

        // Reset in the middle of an EN pulse with bytes queued.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            sb.push_back({1'b1, 8'h50 + 8'(i)});
            write_byte(1'b1, 8'h50 + 8'(i));
        end
        c = -1;
        for (int i = 0; i < 100; i++) begin
            if (lcd_en) begin
                c = cyc;
                break;
            end
            tick();
        end
        chk("t4_en_seen", lcd_en, 1);
        tick();
        tick();
        chk("t4_queued", status[7:4], 3);
        rst_n = 1'b0;
        tick();
        chk("t4_en_low", lcd_en, 0);
        chk("t4_status", status, 32'h0000_0004);
        tick();
        sb.delete();
        rise_q.delete();
        fall_q.delete();
        release_reset();
        n0 = rise_q.size();
        repeat (300) tick();
        chk("t4_no_pulse", rise_q.size() - n0, 0);
        chk("t4_idle_status", status & 32'hFFFF_FFF7, 32'h0000_0004);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
